// File: rtl/din_debounce_if.sv
// Signal bundle between the raw input pin and the debounced level delivered to
// the shifter's DIN input. The bench drives through master; the debouncer
// uses slave.
interface din_debounce_if;
  logic din;   // raw asynchronous pin (bouncy)
  logic dout;  // debounced level
  logic rise;  // 1-cycle pulse when dout goes 0->1
  logic fall;  // 1-cycle pulse when dout goes 1->0
  logic busy;  // a candidate change is being timed

  modport master (
    output din,
    input  dout, rise, fall, busy
  );

  modport slave (
    input  din,
    output dout, rise, fall, busy
  );
endinterface

// File: rtl/din_debounce.sv
// din_debounce: input conditioner in front of the serial shift stage.
// It synchronises the raw pin through two flops. A level change is accepted
// only after DEB_CYCLES consecutive cycles of agreement. Each accepted edge
// is flagged with a one-cycle rise or fall pulse. All outputs are registered,
// so dout is glitch-free for the slow-clocked shifter downstream.
module din_debounce #(
  parameter int DEB_CYCLES = 500000,  // stable cycles needed, >= 1
  parameter int CNT_W      = 19,      // 2**CNT_W >= DEB_CYCLES
  parameter bit ACTIVE_LOW = 1'b0     // invert the pin before synchronising
) (
  input  logic          CLK,
  input  logic          rs,
  din_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Terminal count. The counter starts at 0 on WAIT entry and is compared with
  // equality. It therefore never needs to wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchroniser. Polarity is applied first, so everything after it
  // sees "1 = active". Reset loads the inactive level.
  always_ff @(posedge CLK) begin
    if (rs) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.din ^ ACTIVE_LOW;
      s2_q <= s1_q;
    end
  end

  // State, counter and registered outputs.
  // Reset wins over everything, including an in-progress WAIT.
  always_ff @(posedge CLK) begin
    if (rs) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic. A reversal of s2 during WAIT aborts the attempt.
  // The next attempt always restarts the count from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce with DEB_CYCLES=8.
// An input driven just after edge 0 should show on dout at edge 11.
module tb_din_debounce;

  localparam int DEB = 8;

  logic clk;
  logic rs;
  int   checks;
  int   errors;

  din_debounce_if bus ();

  din_debounce #(
    .DEB_CYCLES (DEB),
    .CNT_W      (4),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .CLK (clk),
    .rs  (rs),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge. Then settle so that sampling happens away from
  // the edge and new drives land before the next one.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic lvl);
    bus.din = lvl;
    for (int i = 0; i < DEB + 6; i++) tick();
  endtask

  task automatic test_reset;
    bus.din = 1'b1;
    rs      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({bus.dout, bus.rise, bus.fall, bus.busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d outs=%b expected 0000", k,
                 {bus.dout, bus.rise, bus.fall, bus.busy});
      end
    end
    rs = 1'b0;
    for (int k = 1; k <= DEB + 4; k++) begin
      tick();
      checks++;
      if (bus.dout !== (k >= DEB + 3) || bus.rise !== (k == DEB + 3) ||
          bus.fall !== 1'b0 || bus.busy !== (k >= 3 && k <= DEB + 2)) begin
        errors++;
        $display("FAIL reset_release edge=%0d dout/rise/fall/busy=%b%b%b%b expected %b%b0%b",
                 k, bus.dout, bus.rise, bus.fall, bus.busy,
                 (k >= DEB + 3), (k == DEB + 3), (k >= 3 && k <= DEB + 2));
      end
    end
  endtask

  task automatic test_release;
    bus.din = 1'b0;
    for (int k = 1; k <= DEB + 4; k++) begin
      tick();
      checks++;
      if (bus.dout !== (k < DEB + 3) || bus.fall !== (k == DEB + 3) ||
          bus.rise !== 1'b0 || bus.busy !== (k >= 3 && k <= DEB + 2)) begin
        errors++;
        $display("FAIL release edge=%0d dout/rise/fall/busy=%b%b%b%b expected %b0%b%b",
                 k, bus.dout, bus.rise, bus.fall, bus.busy,
                 (k < DEB + 3), (k == DEB + 3), (k >= 3 && k <= DEB + 2));
      end
    end
  endtask

  task automatic test_clean_step;
    bus.din = 1'b1;
    for (int k = 1; k <= DEB + 4; k++) begin
      tick();
      checks++;
      if (bus.dout !== (k >= DEB + 3) || bus.rise !== (k == DEB + 3) ||
          bus.fall !== 1'b0 || bus.busy !== (k >= 3 && k <= DEB + 2)) begin
        errors++;
        $display("FAIL clean_step edge=%0d dout/rise/fall/busy=%b%b%b%b expected %b%b0%b",
                 k, bus.dout, bus.rise, bus.fall, bus.busy,
                 (k >= DEB + 3), (k == DEB + 3), (k >= 3 && k <= DEB + 2));
      end
    end
  endtask

  task automatic test_bounce;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int p = 0; p < 4; p++) begin
      bus.din = pat[p];
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (bus.rise !== 1'b0 || bus.dout !== 1'b0) begin
          errors++;
          $display("FAIL bounce_phase seg=%0d cyc=%0d dout=%b rise=%b expected 0 0",
                   p, c, bus.dout, bus.rise);
        end
      end
    end
    bus.din = 1'b1;
    for (int k = 1; k <= DEB + 4; k++) begin
      tick();
      checks++;
      if (bus.dout !== (k >= DEB + 3) || bus.rise !== (k == DEB + 3)) begin
        errors++;
        $display("FAIL bounce_settle edge=%0d dout=%b rise=%b expected %b %b",
                 k, bus.dout, bus.rise, (k >= DEB + 3), (k == DEB + 3));
      end
    end
  endtask

  task automatic test_glitch;
    // The pin is high for 5 cycles. WAIT_HI spans edges 3..7 and aborts at
    // edge 8, well short of the 8 counting edges.
    for (int k = 1; k <= DEB + 6; k++) begin
      bus.din = (k <= 5);
      tick();
      checks++;
      if (bus.dout !== 1'b0 || bus.rise !== 1'b0 || bus.fall !== 1'b0 ||
          bus.busy !== (k >= 3 && k <= 7)) begin
        errors++;
        $display("FAIL glitch edge=%0d dout/rise/fall/busy=%b%b%b%b expected 000%b",
                 k, bus.dout, bus.rise, bus.fall, bus.busy, (k >= 3 && k <= 7));
      end
    end
    bus.din = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    bus.din = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.dout !== 1'b0) begin
      errors++;
      $display("FAIL midwait_pre busy=%b dout=%b expected 1 0", bus.busy, bus.dout);
    end
    rs = 1'b1;
    tick();
    checks++;
    if ({bus.dout, bus.rise, bus.fall, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midwait_reset outs=%b expected 0000",
               {bus.dout, bus.rise, bus.fall, bus.busy});
    end
    rs = 1'b0;
    for (int k = 1; k <= DEB + 4; k++) begin
      tick();
      checks++;
      if (bus.dout !== (k >= DEB + 3) || bus.rise !== (k == DEB + 3) ||
          bus.busy !== (k >= 3 && k <= DEB + 2)) begin
        errors++;
        $display("FAIL midwait_recover edge=%0d dout/rise/busy=%b%b%b expected %b%b%b",
                 k, bus.dout, bus.rise, bus.busy,
                 (k >= DEB + 3), (k == DEB + 3), (k >= 3 && k <= DEB + 2));
      end
    end
  endtask

  initial begin
    clk     = 1'b0;
    rs      = 1'b1;
    bus.din = 1'b0;
    checks  = 0;
    errors  = 0;
    #2;
    test_reset();          // leaves dout=1
    test_release();        // leaves dout=0
    test_clean_step();     // leaves dout=1
    settle(1'b0);
    test_bounce();         // leaves dout=1
    settle(1'b0);
    test_glitch();         // leaves dout=0
    settle(1'b0);
    test_reset_mid_wait(); // leaves dout=1
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
